// File: rtl/zap_fetch_seq.sv
// zap_fetch_seq: instruction fetch sequencer for a pipelined stall/ack bus.
// Keeps up to OUTST requests in flight plus buffered responses, tags every
// returned word with its fetch address and supports a flush/redirect.
// Optional feature: define ZAP_FETCH_ERR_EN to treat i_wb_err as a response
// that delivers an aborted (o_abort=1, o_instr=0) word downstream.
module zap_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned OUTST    = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic [31:0] i_clear_pc,
  input  logic        i_halt,
  output logic        o_wb_stb,
  output logic [31:0] o_wb_adr,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_err,
  input  logic        i_fifo_full,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_abort
);

`ifdef ZAP_FETCH_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int unsigned CW   = $clog2(OUTST + 1);
  localparam int unsigned SW   = CW + 1;
  localparam int unsigned PW   = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam logic [SW-1:0] CAP  = SW'(OUTST);
  localparam logic [PW-1:0] LAST = PW'(OUTST - 1);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t        state;
  logic [31:0]   issue_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outst_cnt;
  logic [CW-1:0] kill_cnt;
  logic [CW-1:0] skid_cnt;
  logic [CW-1:0] outst_nxt_c;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   skid_instr [OUTST];
  logic [31:0]   skid_pc    [OUTST];
  logic          skid_abort [OUTST];

  logic          resp_c;
  logic          accept_c;
  logic          push_c;
  logic          pop_c;
  logic [SW-1:0] used_c;
  logic [31:0]   clear_pc_c;
  logic [31:0]   entry_instr_c;
  logic          entry_abort_c;
  logic          unused_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // A response completes the oldest in-flight request; err only counts when enabled.
  assign resp_c        = (i_wb_ack || (ERR_EN && i_wb_err)) && (outst_cnt != '0);
  assign entry_instr_c = i_wb_ack ? i_wb_dat : 32'h0;
  assign entry_abort_c = !i_wb_ack;
  assign clear_pc_c    = {i_clear_pc[31:2], 2'b00};
  assign unused_ok     = ^i_clear_pc[1:0];

  // Request only while fetching, not flushing, and with room for every reply.
  assign used_c   = SW'(outst_cnt) + SW'(skid_cnt);
  assign o_wb_stb = !i_reset && (state == FETCH) && !i_clear && (used_c < CAP);
  assign o_wb_adr = issue_pc;
  assign accept_c = o_wb_stb && !i_wb_stall;

  // Responses belonging to flushed requests are dropped instead of buffered.
  assign push_c  = resp_c && !i_clear && (kill_cnt == '0);
  assign o_valid = (skid_cnt != '0) && !i_fifo_full && !i_clear;
  assign pop_c   = o_valid;
  assign o_instr = skid_instr[rd_ptr];
  assign o_pc    = skid_pc[rd_ptr];
  assign o_abort = ERR_EN && skid_abort[rd_ptr];

  // Outstanding count after this cycle's accept and response.
  always_comb begin
    outst_nxt_c = outst_cnt;
    if (accept_c && !resp_c) begin
      outst_nxt_c = outst_cnt + CW'(1);
    end else if (!accept_c && resp_c) begin
      outst_nxt_c = outst_cnt - CW'(1);
    end
  end

  // Halt control; a stalled request stays on the bus until accepted.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= FETCH;
    end else if (i_clear) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH: if (i_halt && !(o_wb_stb && i_wb_stall)) state <= HOLD;
        HOLD:  if (!i_halt) state <= FETCH;
      endcase
    end
  end

  // Issue address and the address of the oldest live in-flight request.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      issue_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else if (i_clear) begin
      issue_pc <= clear_pc_c;
      resp_pc  <= clear_pc_c;
    end else begin
      if (accept_c) issue_pc <= issue_pc + 32'd4;
      if (push_c)   resp_pc  <= resp_pc + 32'd4;
    end
  end

  // In-flight and to-be-discarded response counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      outst_cnt <= '0;
      kill_cnt  <= '0;
    end else begin
      outst_cnt <= outst_nxt_c;
      if (i_clear) begin
        kill_cnt <= outst_nxt_c;
      end else if (resp_c && (kill_cnt != '0)) begin
        kill_cnt <= kill_cnt - CW'(1);
      end
    end
  end

  // Skid buffer: circular queue of returned words with their fetch addresses.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      skid_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int unsigned i = 0; i < OUTST; i++) begin
        skid_instr[i] <= '0;
        skid_pc[i]    <= '0;
        skid_abort[i] <= 1'b0;
      end
    end else if (i_clear) begin
      skid_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (push_c) begin
        skid_instr[wr_ptr] <= entry_instr_c;
        skid_pc[wr_ptr]    <= resp_pc;
        skid_abort[wr_ptr] <= entry_abort_c;
        wr_ptr             <= ptr_inc(wr_ptr);
      end
      if (pop_c) rd_ptr <= ptr_inc(rd_ptr);
      if (push_c && !pop_c) begin
        skid_cnt <= skid_cnt + CW'(1);
      end else if (pop_c && !push_c) begin
        skid_cnt <= skid_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_zap_fetch_seq.sv
// tb_zap_fetch_seq: randomized bus/FIFO environment with a scoreboard.
// The driver plays the bus slave and keeps a request-level model (queue of
// in-flight addresses, kill marks); the monitor checks every downstream word.
`timescale 1ns/1ps
module tb_zap_fetch_seq;

  localparam int unsigned OUTST    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef ZAP_FETCH_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset, i_clear, i_halt, i_wb_stall, i_wb_ack, i_wb_err, i_fifo_full;
  logic [31:0] i_clear_pc, i_wb_dat;
  logic        o_wb_stb, o_valid, o_abort;
  logic [31:0] o_wb_adr, o_instr, o_pc;

  always #5 i_clk = ~i_clk;

  zap_fetch_seq #(.RESET_PC(RESET_PC), .OUTST(OUTST)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .i_clear_pc(i_clear_pc),
    .i_halt(i_halt), .o_wb_stb(o_wb_stb), .o_wb_adr(o_wb_adr), .i_wb_stall(i_wb_stall),
    .i_wb_ack(i_wb_ack), .i_wb_dat(i_wb_dat), .i_wb_err(i_wb_err),
    .i_fifo_full(i_fifo_full), .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc),
    .o_abort(o_abort)
  );

  typedef struct packed { logic [31:0] adr; logic kill; } infl_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; logic abort; } exp_t;

  infl_t       infl_q[$];
  exp_t        exp_q[$];
  logic [31:0] m_pc;
  int          errors = 0;
  int          checks = 0;
  int          n_accept;
  int          stall_hits;
  logic        err8_done;

  int          stall_pct, ack_pct, full_pct, halt_pct, clear_pct, err_pct;
  logic        k_reset, k_clear, k_full, k_stall10, k_err8;
  logic [31:0] k_clear_pc;
  logic        cap_armed, cap_done;
  logic [31:0] cap_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic roll(input int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  // Driver: bus slave, flow-control inputs and the request-level model.
  initial begin : drv
    infl_t f;
    i_reset = 1'b1; i_clear = 1'b0; i_clear_pc = '0; i_halt = 1'b0; i_wb_stall = 1'b0;
    i_wb_ack = 1'b0; i_wb_dat = '0; i_wb_err = 1'b0; i_fifo_full = 1'b0;
    m_pc = RESET_PC; n_accept = 0; stall_hits = 0; err8_done = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!k_stall10) stall_hits = 0;
      if (!k_err8) err8_done = 1'b0;
      i_reset     = k_reset;
      i_clear     = k_clear || (!k_reset && roll(clear_pct));
      i_clear_pc  = k_clear ? k_clear_pc : $urandom();
      i_halt      = roll(halt_pct);
      i_fifo_full = k_full || roll(full_pct);
      if (k_stall10 && stall_hits < 3 && (stall_hits > 0 || o_wb_adr == 32'h10)) begin
        i_wb_stall = 1'b1;
        stall_hits++;
      end else begin
        i_wb_stall = roll(stall_pct);
      end
      i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = $urandom();
      if (!k_reset && infl_q.size() > 0) begin
        if (k_err8 && !err8_done && infl_q[0].adr == 32'h8) begin
          i_wb_err  = 1'b1;
          err8_done = 1'b1;
        end else if (roll(ack_pct)) begin
          i_wb_ack = 1'b1;
        end else begin
          i_wb_err = roll(err_pct);
        end
      end
      #2;
      if (i_reset) begin
        infl_q.delete(); exp_q.delete(); m_pc = RESET_PC; n_accept = 0;
      end else begin
        if (o_wb_stb && !i_wb_stall) begin
          chk("issue_adr", o_wb_adr, m_pc);
          infl_q.push_back('{adr: m_pc, kill: 1'b0});
          m_pc = m_pc + 32'd4;
          n_accept++;
        end
        if ((i_wb_ack || (ERR_EN && i_wb_err)) && infl_q.size() > 0) begin
          f = infl_q.pop_front();
          if (!f.kill && !i_clear)
            exp_q.push_back('{pc: f.adr, instr: (i_wb_ack ? i_wb_dat : 32'h0), abort: !i_wb_ack});
        end
        if (i_clear) begin
          foreach (infl_q[i]) infl_q[i].kill = 1'b1;
          exp_q.delete();
          m_pc = {i_clear_pc[31:2], 2'b00};
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT writes a word downstream.
  initial begin : mon
    exp_t        e;
    logic        prev_hold;
    logic [31:0] prev_adr;
    logic        exp_valid;
    int          occ;
    prev_hold = 1'b0; prev_adr = '0;
    forever begin
      @(negedge i_clk);
      #1;
      if (i_reset) begin
        chk("rst_stb", 32'(o_wb_stb), 32'h0);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_abort", 32'(o_abort), 32'h0);
        chk("rst_instr", o_instr, 32'h0);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_adr", o_wb_adr, RESET_PC);
        prev_hold = 1'b0;
      end else begin
        occ = infl_q.size() + exp_q.size();
        exp_valid = (exp_q.size() > 0) && !i_fifo_full && !i_clear;
        chk("o_valid", 32'(o_valid), 32'(exp_valid));
        if (o_valid && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("o_pc", o_pc, e.pc);
          chk("o_instr", o_instr, e.instr);
          chk("o_abort", 32'(o_abort), 32'(e.abort));
          if (cap_armed) begin
            cap_pc = o_pc; cap_done = 1'b1; cap_armed = 1'b0;
          end
        end
        chk("stb_cap", 32'(o_wb_stb && (occ >= int'(OUTST))), 32'h0);
        chk("stb_clear", 32'(o_wb_stb && i_clear), 32'h0);
        if (prev_hold && !i_clear) begin
          chk("stall_stb", 32'(o_wb_stb), 32'h1);
          chk("stall_adr", o_wb_adr, prev_adr);
        end
        prev_hold = o_wb_stb && i_wb_stall;
        prev_adr  = o_wb_adr;
      end
    end
  end

  task automatic do_reset();
    k_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    k_reset = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge i_clk);
  endtask

  // Main sequence: directed scenarios, then randomized traffic and a drain.
  initial begin
    k_reset = 1'b1; k_clear = 1'b0; k_full = 1'b0; k_stall10 = 1'b0; k_err8 = 1'b0;
    k_clear_pc = '0; cap_armed = 1'b0; cap_done = 1'b0; cap_pc = '0;
    stall_pct = 0; ack_pct = 100; full_pct = 0; halt_pct = 0; clear_pct = 0; err_pct = 0;

    // Zero-wait bus, FIFO never full.
    do_reset();
    cycles(20);
    chk("zero_wait_rate", 32'(n_accept >= 10), 32'h1);

    // Stall for three cycles at address 0x10.
    k_stall10 = 1'b1;
    do_reset();
    cycles(25);
    chk("stall_hits", 32'(stall_hits), 32'd3);
    chk("post_stall_progress", 32'(m_pc > 32'h14), 32'h1);
    k_stall10 = 1'b0;

    // Downstream FIFO full: buffer fills, requests stop, then drains in order.
    k_full = 1'b1;
    do_reset();
    cycles(10);
    @(negedge i_clk); #3;
    chk("full_accepts", 32'(n_accept), 32'd2);
    chk("full_buffered", 32'(exp_q.size()), 32'd2);
    chk("full_stb", 32'(o_wb_stb), 32'h0);
    k_full = 1'b0;
    cycles(15);

    // Flush with two requests outstanding.
    ack_pct = 0;
    do_reset();
    cycles(6);
    @(negedge i_clk); #3;
    chk("pre_clear_outst", 32'(infl_q.size()), 32'd2);
    chk("pre_clear_stb", 32'(o_wb_stb), 32'h0);
    k_clear = 1'b1; k_clear_pc = 32'h103; ack_pct = 100; cap_done = 1'b0; cap_armed = 1'b1;
    @(negedge i_clk); #3;
    k_clear = 1'b0;
    cycles(12);
    chk("clear_first_seen", 32'(cap_done), 32'h1);
    chk("clear_first_pc", cap_pc, 32'h100);

    // Error response on the request at 0x8.
    k_err8 = 1'b1;
    do_reset();
    cycles(15);
    chk("err8_done", 32'(err8_done), 32'h1);
    k_err8 = 1'b0;

    // Randomized traffic with a reset in the middle of operation.
    stall_pct = 30; ack_pct = 60; full_pct = 20; halt_pct = 10; clear_pct = 3; err_pct = 10;
    cycles(400);
    do_reset();
    cycles(400);

    // Drain: no new requests, bus and FIFO fully responsive.
    stall_pct = 0; ack_pct = 100; full_pct = 0; halt_pct = 100; clear_pct = 0; err_pct = 0;
    cycles(30);
    @(negedge i_clk); #3;
    chk("drain_inflight", 32'(infl_q.size()), 32'd0);
    chk("drain_words", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
